phy_rx_s2p_lanes: RTL and testbench
===================================

# phy_rx_s2p_lanes

Parametrised multi-lane serial-to-parallel receiver for the PHY receive path, running entirely on the fast serial clock. Each lane:
- Hunts for a comma word at any bit offset and locks word alignment to it.
- Declares itself active after a programmable number of consecutive aligned commas.
- Then emits each non-comma word as a one-cycle `valid` strobe.

It adds to the single-lane 8-bit receiver: arbitrary word width and lane count, bit-slip alignment, and loss-of-sync detection.

## Interface
Parameters:
- `WIDTH`, 8: bits per word.
- `LANES`, 1: number of independent serial lanes.
- `COM`, 8'hBC: comma word, `WIDTH` bits.
- `COM_COUNT`, 4: consecutive aligned commas required to enter ACTIVE (≥1).
- `MAX_GAP`, 0: in ACTIVE, number of consecutive non-comma words that forces resync; 0 disables.

Ports:
- `clk_32f`  in  1  serial bit clock, rising edge. One clock only.
- `default_values`  in  1  reset: synchronous, active-low (0 = reset).
- `data_in`  in  `LANES`  serial bit per lane, MSB of each word first.
- `data_out`  out  `LANES*WIDTH`  last received data word per lane; lane i at `[i*WIDTH +: WIDTH]`.
- `valid`  out  `LANES`  one-cycle strobe per lane: new data word on `data_out`.
- `active`  out  `LANES`  per-lane state is ACTIVE.
- `active_all`  out  1  AND of `active`.

## Operation
Per lane, define `nxt = {shreg[WIDTH-2:0], data_in[i]}`. Every edge, `shreg <= nxt`.

The per-lane FSM has states HUNT, SYNC, ACTIVE:
- **HUNT**
  - If `nxt == COM`: go to SYNC, `com_cnt <= 1`, `bit_cnt <= 0`.
  - If `COM_COUNT == 1`: go directly to ACTIVE instead.
- **SYNC**
  - `bit_cnt` increments modulo `WIDTH`. A word boundary is when `bit_cnt == WIDTH-1`.
  - At a boundary with `nxt == COM`: `com_cnt++`. On reaching `COM_COUNT`, go to ACTIVE with `gap_cnt <= 0`.
  - At a boundary with `nxt != COM`: go to HUNT, `com_cnt <= 0`.
- **ACTIVE**
  - At a boundary with `nxt == COM`: no strobe, `gap_cnt <= 0`.
  - At a boundary with `nxt != COM`: `data_out` lane ← `nxt`, `valid <= 1`, `gap_cnt++`.
  - If `MAX_GAP != 0` and `gap_cnt` would reach `MAX_GAP`: the word is still delivered, then the lane goes to HUNT.
- Outside a delivering boundary, `valid <= 0`. `data_out` holds its value.
- Lanes are fully independent. There is no deskew between lanes.
- Counter widths:
  - `bit_cnt`: `$clog2(WIDTH)`.
  - `com_cnt`: `$clog2(COM_COUNT+1)`.
  - `gap_cnt`: `$clog2(MAX_GAP+1)`, saturating.

## Timing
- Reset (`default_values == 0` at an edge) forces, on that edge:
  - `state = HUNT`; all counters 0; `shreg = 0`.
  - `data_out = 0`; `valid = 0`; `active = 0`; `active_all = 0`.
- Reset mid-word or while ACTIVE drops `active` on that same edge. Bits sampled during reset are discarded.
- Latency: the edge that samples a word's last bit updates `data_out`/`valid` (valid visible for the following cycle).
- `active` rises on the edge that samples the last bit of the `COM_COUNT`-th comma. It falls on the edge of a SYNC mismatch, the edge of the `MAX_GAP` word, or reset.
- In HUNT, detection is bit-granular: any offset of `COM` in the stream aligns. A comma completing in HUNT on the same edge reset deasserts is not detected (reset wins).
- `valid` is never high on two consecutive edges when `WIDTH > 1`.

## Structure
- Shared package `phy_rx_pkg`:
  - state enum (HUNT/SYNC/ACTIVE);
  - default `COM` value 8'hBC;
  - default `COM_COUNT`.
- One sub-module `phy_rx_s2p_lane`: single-lane shifter, counters and FSM, with scalar ports.
- The top generates `LANES` instances and the `active_all` AND reduction.

## Test plan
- `LANES=1`, `WIDTH=8`: reset one cycle, then 4×BC aligned, then 0x55, 0xA5.
  - `active` rises at bit 32.
  - `valid` pulses at bits 40 and 48 with `data_out` 0x55 then 0xA5.
  - No strobe for the BC words.
- Three junk bits `101`, then 4×BC, then 0x3C → aligns at offset 3; `active` rises at bit 35; `data_out` = 0x3C.
- 3×BC then 0x00 → `active` stays 0, lane returns to HUNT. Then 4×BC → `active` rises.
- `MAX_GAP=2`, active lane, stream 0x11, 0x22, 0x33:
  - 0x11 and 0x22 delivered; `active` falls on the 0x22 edge.
  - 0x33 not delivered.
- Reset asserted mid-word while ACTIVE → all outputs 0 on that edge; 4 fresh BC required to reactivate.
- `LANES=2`: lane 1 delayed by 5 bits relative to lane 0 → each lane activates independently; `active_all` rises only when lane 1 activates.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the serial-to-parallel receive lanes: lane states,
// default comma settings and a counter-width helper.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  localparam logic [7:0] COM_DEFAULT       = 8'hBC;
  localparam int         COM_COUNT_DEFAULT = 4;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phy_rx_s2p_lane.sv
// One serial receive lane: bit shifter, comma hunt, word framing and
// loss-of-sync detection, all on the serial bit clock.
//
// state  | meaning
// HUNT   | searching every bit offset for a comma
// SYNC   | aligned on a comma, counting consecutive aligned commas
// ACTIVE | locked; non-comma words are delivered with a valid strobe
module phy_rx_s2p_lane
  import phy_rx_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_DEFAULT),
  parameter int               COM_COUNT = COM_COUNT_DEFAULT,
  parameter int               MAX_GAP   = 0
) (
  input  logic             clk_32f,
  input  logic             default_values,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             active
);

  localparam int SW  = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam int BCW = cnt_width(WIDTH);
  localparam int CCW = cnt_width(COM_COUNT + 1);
  localparam int GCW = cnt_width(MAX_GAP + 1);

  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] COM_LAST = CCW'(COM_COUNT - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((MAX_GAP > 0) ? MAX_GAP - 1 : 0);
  localparam logic [GCW-1:0] GAP_SAT  = '1;

  rx_state_e        state;
  logic [SW-1:0]    hist;
  logic [BCW-1:0]   bit_cnt;
  logic [CCW-1:0]   com_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic [WIDTH-1:0] nxt;
  logic             is_com;
  logic             boundary;

  // Only WIDTH-1 history bits are kept: the oldest bit falls out of the
  // word window on the same edge the newest one arrives.
  if (WIDTH > 1) begin : g_shift
    assign nxt = {hist, data_in};
  end else begin : g_bit
    assign nxt = data_in;
  end

  assign is_com   = (nxt == COM);
  assign boundary = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk_32f) begin
    if (!default_values) begin
      state    <= HUNT;
      hist     <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      gap_cnt  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      active   <= 1'b0;
    end else begin
      hist    <= nxt[SW-1:0];
      valid   <= 1'b0;
      bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;

      case (state)
        HUNT: begin
          if (is_com) begin
            bit_cnt <= '0;
            com_cnt <= CCW'(1);
            if (COM_COUNT == 1) begin
              state   <= ACTIVE;
              active  <= 1'b1;
              gap_cnt <= '0;
            end else begin
              state <= SYNC;
            end
          end
        end

        SYNC: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt <= com_cnt + 1'b1;
              if (com_cnt == COM_LAST) begin
                state   <= ACTIVE;
                active  <= 1'b1;
                gap_cnt <= '0;
              end
            end else begin
              state   <= HUNT;
              com_cnt <= '0;
            end
          end
        end

        ACTIVE: begin
          if (boundary) begin
            if (is_com) begin
              gap_cnt <= '0;
            end else begin
              data_out <= nxt;
              valid    <= 1'b1;
              // The word that exhausts the gap budget is still delivered.
              if (MAX_GAP != 0 && gap_cnt == GAP_LAST) begin
                state   <= HUNT;
                active  <= 1'b0;
                gap_cnt <= '0;
                com_cnt <= '0;
              end else if (gap_cnt != GAP_SAT) begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state  <= HUNT;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_s2p_lanes.sv
// Multi-lane serial-to-parallel receiver: independent lanes with no deskew,
// plus an all-lanes-active summary.
module phy_rx_s2p_lanes
  import phy_rx_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 1,
  parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_DEFAULT),
  parameter int               COM_COUNT = COM_COUNT_DEFAULT,
  parameter int               MAX_GAP   = 0
) (
  input  logic                   clk_32f,
  input  logic                   default_values,
  input  logic [LANES-1:0]       data_in,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid,
  output logic [LANES-1:0]       active,
  output logic                   active_all
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_rx_s2p_lane #(
      .WIDTH     (WIDTH),
      .COM       (COM),
      .COM_COUNT (COM_COUNT),
      .MAX_GAP   (MAX_GAP)
    ) u_lane (
      .clk_32f        (clk_32f),
      .default_values (default_values),
      .data_in        (data_in[i]),
      .data_out       (data_out[i*WIDTH +: WIDTH]),
      .valid          (valid[i]),
      .active         (active[i])
    );
  end

  assign active_all = &active;

endmodule

// File: tb/tb_phy_rx_s2p_lanes.sv
// Bench for phy_rx_s2p_lanes: a two-lane instance and a single-lane MAX_GAP=2
// instance, checked edge by edge against a word-level stream model.
module tb_phy_rx_s2p_lanes;

  localparam int         W     = 8;
  localparam int         NCOM  = 4;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         NMAX  = 512;

  logic        clk_32f = 1'b0;
  logic        default_values;
  logic [1:0]  data_in;
  logic [15:0] data_out;
  logic [1:0]  valid;
  logic [1:0]  active;
  logic        active_all;
  logic        gap_in;
  logic [7:0]  gap_data;
  logic        gap_valid, gap_active, gap_all;

  always #5 clk_32f = ~clk_32f;

  phy_rx_s2p_lanes #(.WIDTH(8), .LANES(2), .COM_COUNT(4), .MAX_GAP(0)) u_dut (
    .clk_32f(clk_32f), .default_values(default_values), .data_in(data_in),
    .data_out(data_out), .valid(valid), .active(active), .active_all(active_all));

  phy_rx_s2p_lanes #(.WIDTH(8), .LANES(1), .COM_COUNT(4), .MAX_GAP(2)) u_gap (
    .clk_32f(clk_32f), .default_values(default_values), .data_in(gap_in),
    .data_out(gap_data), .valid(gap_valid), .active(gap_active), .active_all(gap_all));

  int total = 0;
  int bad   = 0;

  // Streams: st[lane][edge], edge 1 is the first bit after reset release.
  bit st[2][NMAX];
  int len[2];
  // Model / observed outputs: index 0,1 = u_dut lanes, 2 = u_gap.
  logic       mv[3][NMAX];
  logic [7:0] md[3][NMAX];
  logic       ma[3][NMAX];
  logic       ov[3][NMAX];
  logic [7:0] od[3][NMAX];
  logic       oa[3][NMAX];
  logic       oall[NMAX];
  logic       gall[NMAX];

  task automatic clear_streams();
    for (int l = 0; l < 2; l++) begin
      len[l] = 0;
      for (int x = 0; x < NMAX; x++) st[l][x] = 1'b0;
    end
  endtask

  task automatic push(input int ln, input logic [7:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) begin
      len[ln]++;
      st[ln][len[ln]] = v[k];
    end
  endtask

  // Last W bits of a lane's stream ending at edge c (pre-stream bits are 0).
  function automatic logic [7:0] win(input int ln, input int c);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = c - (W - 1) + k;
      w = {w[6:0], (idx >= 1 && st[ln][idx])};
    end
    return w;
  endfunction

  // Word-level reference: find a comma anywhere, require NCOM in a row at
  // word spacing, then walk words until the gap budget (if any) runs out.
  function automatic void run_model(input int m, input int ln, input int gap_lim, input int n);
    int t, c, k, a, e, ex, gap;
    logic [7:0] w, last;
    for (int x = 0; x < NMAX; x++) begin
      mv[m][x] = 1'b0; md[m][x] = '0; ma[m][x] = 1'b0;
    end
    t = 1;
    while (t <= n) begin
      c = t;
      while (c <= n && win(ln, c) != COMMA) c++;
      if (c > n) break;
      k = 1;
      while (k < NCOM && c + W*k <= n && win(ln, c + W*k) == COMMA) k++;
      if (k < NCOM) begin
        t = c + W*k + 1;
        continue;
      end
      a = c + W*(NCOM-1);
      ex = n + 1;
      gap = 0;
      for (e = a + W; e <= n; e += W) begin
        w = win(ln, e);
        if (w == COMMA) gap = 0;
        else begin
          mv[m][e] = 1'b1; md[m][e] = w; gap++;
          if (gap_lim != 0 && gap >= gap_lim) begin ex = e; break; end
        end
      end
      for (int x = a; x < ex; x++) ma[m][x] = 1'b1;
      t = ex + 1;
    end
    last = '0;
    for (int x = 1; x <= n; x++) begin
      if (mv[m][x]) last = md[m][x];
      md[m][x] = last;
    end
  endfunction

  function automatic int max_len();
    return (len[0] > len[1]) ? len[0] : len[1];
  endfunction

  task automatic models(input int n);
    run_model(0, 0, 0, n);
    run_model(1, 1, 0, n);
    run_model(2, 0, 2, n);
  endtask

  task automatic apply_reset();
    default_values = 1'b0;
    data_in = 2'b11;
    gap_in  = 1'b1;
    @(posedge clk_32f); @(negedge clk_32f);
    default_values = 1'b1;
  endtask

  task automatic play(input int n);
    for (int t = 1; t <= n; t++) begin
      data_in = {st[1][t], st[0][t]};
      gap_in  = st[0][t];
      @(posedge clk_32f); @(negedge clk_32f);
      ov[0][t] = valid[0]; od[0][t] = data_out[7:0];  oa[0][t] = active[0];
      ov[1][t] = valid[1]; od[1][t] = data_out[15:8]; oa[1][t] = active[1];
      ov[2][t] = gap_valid; od[2][t] = gap_data; oa[2][t] = gap_active;
      oall[t] = active_all; gall[t] = gap_all;
    end
  endtask

  task automatic test_reset();
    data_in = 2'b11; gap_in = 1'b1;
    @(posedge clk_32f); @(negedge clk_32f);
    @(posedge clk_32f); @(negedge clk_32f);
    total++;
    if ({data_out, valid, active, active_all} !== 21'd0) begin
      bad++;
      $display("FAIL reset_dut got d=%h v=%b a=%b all=%b want all zero", data_out, valid, active, active_all);
    end
    total++;
    if ({gap_data, gap_valid, gap_active, gap_all} !== 11'd0) begin
      bad++;
      $display("FAIL reset_gap got d=%h v=%b a=%b all=%b want all zero", gap_data, gap_valid, gap_active, gap_all);
    end
  endtask

  task automatic test_aligned();
    int n, nv;
    apply_reset();
    clear_streams();
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h55, 8); push(0, 8'hA5, 8);
    n = max_len(); models(n); play(n);
    for (int t = 1; t <= n; t++) begin
      for (int m = 0; m < 3; m++) begin
        total++;
        if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
          bad++;
          $display("FAIL aligned m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
        end
      end
      total++;
      if ({oall[t], gall[t]} !== {ma[0][t] & ma[1][t], ma[2][t]}) begin
        bad++; $display("FAIL aligned_all t=%0d got %b%b want %b%b", t, oall[t], gall[t], ma[0][t] & ma[1][t], ma[2][t]);
      end
    end
    total++;
    if (oa[0][31] !== 1'b0 || oa[0][32] !== 1'b1) begin
      bad++; $display("FAIL aligned_rise got %b%b want 01", oa[0][31], oa[0][32]);
    end
    total++;
    if (ov[0][40] !== 1'b1 || od[0][40] !== 8'h55 || ov[0][48] !== 1'b1 || od[0][48] !== 8'hA5) begin
      bad++; $display("FAIL aligned_words got %b/%h %b/%h want 1/55 1/a5", ov[0][40], od[0][40], ov[0][48], od[0][48]);
    end
    nv = 0;
    for (int t = 1; t <= n; t++) nv += int'(ov[0][t]);
    total++;
    if (nv != 2) begin bad++; $display("FAIL aligned_strobes got %0d want 2", nv); end
  endtask

  task automatic test_offset();
    int n;
    apply_reset();
    clear_streams();
    push(0, 8'b101, 3);
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h3C, 8);
    n = max_len(); models(n); play(n);
    for (int t = 1; t <= n; t++) begin
      for (int m = 0; m < 3; m++) begin
        total++;
        if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
          bad++;
          $display("FAIL offset m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
        end
      end
    end
    total++;
    if (oa[0][34] !== 1'b0 || oa[0][35] !== 1'b1) begin
      bad++; $display("FAIL offset_rise got %b%b want 01", oa[0][34], oa[0][35]);
    end
    total++;
    if (ov[0][43] !== 1'b1 || od[0][43] !== 8'h3C) begin
      bad++; $display("FAIL offset_word got %b/%h want 1/3c", ov[0][43], od[0][43]);
    end
  endtask

  task automatic test_resync();
    int n;
    apply_reset();
    clear_streams();
    for (int i = 0; i < 3; i++) push(0, COMMA, 8);
    push(0, 8'h00, 8);
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h5A, 8);
    n = max_len(); models(n); play(n);
    for (int t = 1; t <= n; t++) begin
      for (int m = 0; m < 3; m++) begin
        total++;
        if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
          bad++;
          $display("FAIL resync m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
        end
      end
    end
    total++;
    if (oa[0][32] !== 1'b0 || oa[0][63] !== 1'b0 || oa[0][64] !== 1'b1) begin
      bad++; $display("FAIL resync_active got %b%b%b want 001", oa[0][32], oa[0][63], oa[0][64]);
    end
    total++;
    if (ov[0][72] !== 1'b1 || od[0][72] !== 8'h5A) begin
      bad++; $display("FAIL resync_word got %b/%h want 1/5a", ov[0][72], od[0][72]);
    end
  endtask

  task automatic test_max_gap();
    int n;
    apply_reset();
    clear_streams();
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h11, 8); push(0, 8'h22, 8); push(0, 8'h33, 8);
    n = max_len(); models(n); play(n);
    for (int t = 1; t <= n; t++) begin
      for (int m = 0; m < 3; m++) begin
        total++;
        if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
          bad++;
          $display("FAIL max_gap m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
        end
      end
    end
    total++;
    if (ov[2][40] !== 1'b1 || od[2][40] !== 8'h11 || ov[2][48] !== 1'b1 || od[2][48] !== 8'h22) begin
      bad++; $display("FAIL gap_words got %b/%h %b/%h want 1/11 1/22", ov[2][40], od[2][40], ov[2][48], od[2][48]);
    end
    total++;
    if (oa[2][47] !== 1'b1 || oa[2][48] !== 1'b0) begin
      bad++; $display("FAIL gap_fall got %b%b want 10", oa[2][47], oa[2][48]);
    end
    total++;
    if (ov[2][56] !== 1'b0 || od[2][56] !== 8'h22 || ov[0][56] !== 1'b1 || od[0][56] !== 8'h33) begin
      bad++; $display("FAIL gap_third got gap %b/%h nogap %b/%h want 0/22 1/33", ov[2][56], od[2][56], ov[0][56], od[0][56]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    clear_streams();
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h55, 8);
    push(0, 8'b101, 3);
    n = max_len(); models(n); play(n);
    total++;
    if (oa[0][n] !== ma[0][n] || od[0][n] !== md[0][n] || oa[2][n] !== ma[2][n]) begin
      bad++; $display("FAIL midreset_pre got a=%b d=%h ga=%b want %b/%h/%b", oa[0][n], od[0][n], oa[2][n], ma[0][n], md[0][n], ma[2][n]);
    end
    default_values = 1'b0;
    data_in = 2'b11; gap_in = 1'b1;
    @(posedge clk_32f); @(negedge clk_32f);
    total++;
    if ({data_out, valid, active, active_all, gap_data, gap_valid, gap_active, gap_all} !== 32'd0) begin
      bad++; $display("FAIL midreset_edge got d=%h v=%b a=%b all=%b gd=%h gv=%b ga=%b", data_out, valid, active, active_all, gap_data, gap_valid, gap_active);
    end
    default_values = 1'b1;
    clear_streams();
    for (int i = 0; i < 3; i++) push(0, COMMA, 8);
    push(0, 8'h77, 8);
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h66, 8);
    n = max_len(); models(n); play(n);
    for (int t = 1; t <= n; t++) begin
      for (int m = 0; m < 3; m++) begin
        total++;
        if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
          bad++;
          $display("FAIL midreset m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
        end
      end
    end
    total++;
    if (oa[0][24] !== 1'b0 || oa[0][32] !== 1'b0 || oa[0][64] !== 1'b1 || od[0][72] !== 8'h66) begin
      bad++; $display("FAIL midreset_fresh got %b%b%b d=%h want 001 d=66", oa[0][24], oa[0][32], oa[0][64], od[0][72]);
    end
  endtask

  task automatic test_two_lanes();
    int n;
    apply_reset();
    clear_streams();
    for (int i = 0; i < 4; i++) push(0, COMMA, 8);
    push(0, 8'h55, 8);
    push(1, 8'h00, 5);
    for (int i = 0; i < 4; i++) push(1, COMMA, 8);
    push(1, 8'h66, 8);
    n = max_len(); models(n); play(n);
    for (int t = 1; t <= n; t++) begin
      for (int m = 0; m < 3; m++) begin
        total++;
        if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
          bad++;
          $display("FAIL two_lanes m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
        end
      end
      total++;
      if (oall[t] !== (ma[0][t] & ma[1][t])) begin
        bad++; $display("FAIL two_lanes_all t=%0d got %b want %b", t, oall[t], ma[0][t] & ma[1][t]);
      end
    end
    total++;
    if (oa[0][32] !== 1'b1 || oa[1][36] !== 1'b0 || oa[1][37] !== 1'b1) begin
      bad++; $display("FAIL two_lanes_rise got %b%b%b want 101", oa[0][32], oa[1][36], oa[1][37]);
    end
    total++;
    if (oall[36] !== 1'b0 || oall[37] !== 1'b1) begin
      bad++; $display("FAIL active_all_rise got %b%b want 01", oall[36], oall[37]);
    end
    total++;
    if (ov[1][45] !== 1'b1 || od[1][45] !== 8'h66) begin
      bad++; $display("FAIL lane1_word got %b/%h want 1/66", ov[1][45], od[1][45]);
    end
  endtask

  task automatic test_random();
    int n;
    for (int iter = 0; iter < 6; iter++) begin
      apply_reset();
      clear_streams();
      for (int l = 0; l < 2; l++) begin
        push(l, 8'($urandom), int'($urandom_range(0, 7)));
        if ($urandom_range(0, 3) != 0)
          for (int i = 0; i < 4; i++) push(l, COMMA, 8);
        for (int i = 0; i < 24; i++)
          push(l, ($urandom_range(0, 4) == 0) ? COMMA : 8'($urandom), 8);
      end
      n = max_len(); models(n); play(n);
      for (int t = 1; t <= n; t++) begin
        for (int m = 0; m < 3; m++) begin
          total++;
          if ({ov[m][t], od[m][t], oa[m][t]} !== {mv[m][t], md[m][t], ma[m][t]}) begin
            bad++;
            $display("FAIL random%0d m%0d t=%0d got v/d/a=%b/%h/%b want %b/%h/%b", iter, m, t, ov[m][t], od[m][t], oa[m][t], mv[m][t], md[m][t], ma[m][t]);
          end
        end
        total++;
        if ({oall[t], gall[t]} !== {ma[0][t] & ma[1][t], ma[2][t]}) begin
          bad++; $display("FAIL random%0d_all t=%0d got %b%b want %b%b", iter, t, oall[t], gall[t], ma[0][t] & ma[1][t], ma[2][t]);
        end
      end
    end
  endtask

  initial begin
    default_values = 1'b0;
    data_in = 2'b00;
    gap_in  = 1'b0;
    @(negedge clk_32f);
    test_reset();
    test_aligned();
    test_offset();
    test_resync();
    test_max_gap();
    test_reset_mid();
    test_two_lanes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
